// File: rtl/csr_access_arbiter.sv
// Two-requester (core, debug) arbiter in front of a single CSR file port.
// Optional macro CSR_ARB_AGING_EN adds debug starvation avoidance via an age counter.
//
// state  | meaning
// IDLE   | no transaction; arbitrate incoming requests
// ACCESS | drive the latched request onto the CSR port, capture read data
// RESP   | pulse owner's rvalid; arbitrate the next request
module csr_access_arbiter #(
    parameter int unsigned AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic [11:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [1:0]  core_op_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    input  logic        dbg_req_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [1:0]  dbg_op_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_dbg_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  op_q;
    logic [31:0] core_rdata_q;
    logic [31:0] dbg_rdata_q;
    logic        grant_core;
    logic        grant_dbg;
    logic        force_dbg;

`ifdef CSR_ARB_AGING_EN
    localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);
    logic [3:0] age_q;

    assign force_dbg = (age_q == AGE_LIM);

    // Counts core wins while debug is waiting; any debug grant restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 4'd0;
        end else if (grant_dbg) begin
            age_q <= 4'd0;
        end else if (grant_core && dbg_req_i) begin
            age_q <= age_q + 4'd1;
        end
    end
`else
    assign force_dbg = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        grant_core    = 1'b0;
        grant_dbg     = 1'b0;
        core_rvalid_o = 1'b0;
        dbg_rvalid_o  = 1'b0;
        csr_access_o  = 1'b0;
        csr_addr_o    = 12'd0;
        csr_wdata_o   = 32'd0;
        csr_op_o      = 2'd0;
        case (state)
            IDLE, RESP: begin
                if (state == RESP) begin
                    core_rvalid_o = ~owner_dbg_q;
                    dbg_rvalid_o  = owner_dbg_q;
                end
                grant_dbg  = dbg_req_i && (!core_req_i || force_dbg);
                grant_core = core_req_i && !grant_dbg;
                state_nxt  = (grant_core || grant_dbg) ? ACCESS : IDLE;
            end
            ACCESS: begin
                csr_access_o = 1'b1;
                csr_addr_o   = addr_q;
                csr_wdata_o  = wdata_q;
                csr_op_o     = op_q;
                state_nxt    = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are combinational from the request; gate them so reset forces them low.
    assign core_gnt_o   = grant_core & rst_n;
    assign dbg_gnt_o    = grant_dbg & rst_n;
    assign core_rdata_o = core_rdata_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_dbg_q  <= 1'b0;
            addr_q       <= 12'd0;
            wdata_q      <= 32'd0;
            op_q         <= 2'd0;
            core_rdata_q <= 32'd0;
            dbg_rdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant_core) begin
                owner_dbg_q <= 1'b0;
                addr_q      <= core_addr_i;
                wdata_q     <= core_wdata_i;
                op_q        <= core_op_i;
            end else if (grant_dbg) begin
                owner_dbg_q <= 1'b1;
                addr_q      <= dbg_addr_i;
                wdata_q     <= dbg_wdata_i;
                op_q        <= dbg_op_i;
            end
            if (state == ACCESS) begin
                if (owner_dbg_q) begin
                    dbg_rdata_q <= csr_rdata_i;
                end else begin
                    core_rdata_q <= csr_rdata_i;
                end
            end
        end
    end

endmodule
